// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential packed-BCD adder: digit geometry,
// controller state encoding and a digit validity helper.
package bcd_pkg;

    localparam int                     BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX     = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Returns 1 when the nibble is a legal decimal digit (0..9).
    function automatic logic is_valid_digit(input logic [BCD_DIGIT_W-1:0] d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_slice.sv
// Single-digit BCD adder. Purely combinational; shared by every digit
// position of the sequential adder. Invalid input digits are not saturated:
// the decimal-adjust rule below is applied to whatever binary sum results.
module bcd_digit_slice
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a_digit,
    input  logic [BCD_DIGIT_W-1:0] b_digit,
    input  logic                   carry_in,
    output logic [BCD_DIGIT_W-1:0] sum_digit,
    output logic                   carry_out
);

    logic [BCD_DIGIT_W:0] raw;

    // Binary add, then decimal-adjust by +6 whenever the raw sum exceeds 9.
    always_comb begin
        raw = {1'b0, a_digit} + {1'b0, b_digit} + {{BCD_DIGIT_W{1'b0}}, carry_in};
        if (raw > {1'b0, BCD_MAX}) begin
            sum_digit = raw[BCD_DIGIT_W-1:0] + 4'd6;
            carry_out = 1'b1;
        end else begin
            sum_digit = raw[BCD_DIGIT_W-1:0];
            carry_out = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_seq_adder.sv
// Multi-digit packed-BCD adder that reuses one digit slice, one digit per
// clock, least significant digit first. The decimal carry ripples through
// carry_q. Handshake: start (accepted in IDLE or DONE), busy, done pulse.
module bcd_seq_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
    input  logic                          cin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
    output logic                          cout,
    output logic                          err
);

    localparam int W     = BCD_DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       opa_q,   opa_d;
    logic [W-1:0]       opb_q,   opb_d;
    logic [W-1:0]       sum_q,   sum_d;
    logic               cout_q,  cout_d;
    logic               err_q,   err_d;

    logic [BCD_DIGIT_W-1:0] slice_a;
    logic [BCD_DIGIT_W-1:0] slice_b;
    logic [BCD_DIGIT_W-1:0] slice_sum;
    logic                   slice_carry;
    logic                   any_invalid;

    // The controller steers the current digit of each latched operand into the slice.
    assign slice_a = opa_q[idx_q*BCD_DIGIT_W +: BCD_DIGIT_W];
    assign slice_b = opb_q[idx_q*BCD_DIGIT_W +: BCD_DIGIT_W];

    bcd_digit_slice u_slice (
        .a_digit   (slice_a),
        .b_digit   (slice_b),
        .carry_in  (carry_q),
        .sum_digit (slice_sum),
        .carry_out (slice_carry)
    );

    // Flag any non-decimal digit in the incoming operands, evaluated at acceptance.
    always_comb begin
        any_invalid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_valid_digit(a[i*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
                !is_valid_digit(b[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
                any_invalid = 1'b1;
            end
        end
    end

    // Next-state and datapath update for the IDLE -> RUN -> DONE controller.
    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path through this
        // block leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    opa_d   = a;
                    opb_d   = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    err_d   = any_invalid;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[idx_q*BCD_DIGIT_W +: BCD_DIGIT_W] = slice_sum;
                carry_d = slice_carry;
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_carry;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            // NOTE: the operand registers are plain flops rather than a RAM,
            // so they are reset too and the slice never sees unknown inputs.
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop capture the
            // pre-edge values prepared in always_comb.
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_seq_adder.sv
// Self-checking bench for bcd_seq_adder. Three builds (4, 1 and 8 digits)
// share one stimulus stream; a decimal reference model predicts handshake
// and results for each, and directed runs pin literal values on the 4-digit build.
module tb_bcd_seq_adder;

    localparam int NI = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cin   = 1'b0;
    logic [31:0] a_in  = '0;
    logic [31:0] b_in  = '0;

    logic [15:0] sum4;
    logic [3:0]  sum1;
    logic [31:0] sum8;
    logic [NI-1:0] busy_v, done_v, cout_v, err_v;
    logic [31:0]   sum_v [NI];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd_seq_adder #(.DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a_in[15:0]), .b(b_in[15:0]),
        .cin(cin), .busy(busy_v[0]), .done(done_v[0]), .sum(sum4),
        .cout(cout_v[0]), .err(err_v[0]));

    bcd_seq_adder #(.DIGITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a_in[3:0]), .b(b_in[3:0]),
        .cin(cin), .busy(busy_v[1]), .done(done_v[1]), .sum(sum1),
        .cout(cout_v[1]), .err(err_v[1]));

    bcd_seq_adder #(.DIGITS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a_in), .b(b_in),
        .cin(cin), .busy(busy_v[2]), .done(done_v[2]), .sum(sum8),
        .cout(cout_v[2]), .err(err_v[2]));

    assign sum_v[0] = {16'h0, sum4};
    assign sum_v[1] = {28'h0, sum1};
    assign sum_v[2] = sum8;

    function automatic int nd_of(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic ref_err(input logic [31:0] av, input logic [31:0] bv, input int nd);
        logic [31:0] x, y;
        x = av;
        y = bv;
        for (int i = 0; i < nd; i++)
            if (x[i*4 +: 4] > 4'd9 || y[i*4 +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    // Returns {cout, sum}. Legal operands use plain decimal arithmetic;
    // operands with illegal digits follow the per-digit +6 adjust rule.
    function automatic logic [32:0] ref_add(input logic [31:0] av, input logic [31:0] bv,
                                            input logic ci, input int nd);
        longint va, vb, pw, s;
        logic [31:0] x, y, r;
        logic c;
        int raw;
        x = av;
        y = bv;
        r = '0;
        if (ref_err(av, bv, nd)) begin
            c = ci;
            for (int i = 0; i < nd; i++) begin
                raw = int'(x[i*4 +: 4]) + int'(y[i*4 +: 4]) + int'(c);
                if (raw > 9) begin
                    r[i*4 +: 4] = 4'(raw + 6);
                    c = 1'b1;
                end else begin
                    r[i*4 +: 4] = 4'(raw);
                    c = 1'b0;
                end
            end
            return {c, r};
        end
        va = 0;
        vb = 0;
        pw = 1;
        for (int i = nd - 1; i >= 0; i--) begin
            va = va * 10 + longint'(x[i*4 +: 4]);
            vb = vb * 10 + longint'(y[i*4 +: 4]);
            pw = pw * 10;
        end
        s = va + vb + longint'(ci);
        c = (s >= pw);
        s = s % pw;
        for (int i = 0; i < nd; i++) begin
            r[i*4 +: 4] = 4'(s % 10);
            s = s / 10;
        end
        return {c, r};
    endfunction

    // Per-build expected handshake/result state, advanced once per clock edge.
    int          m_left [NI] = '{0, 0, 0};
    logic        m_done [NI] = '{1'b0, 1'b0, 1'b0};
    logic        m_cout [NI] = '{1'b0, 1'b0, 1'b0};
    logic        m_err  [NI] = '{1'b0, 1'b0, 1'b0};
    logic [31:0] m_sum  [NI] = '{32'h0, 32'h0, 32'h0};
    logic [32:0] m_pend [NI] = '{33'h0, 33'h0, 33'h0};

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                m_left[k] <= 0;
                m_done[k] <= 1'b0;
                m_sum[k]  <= '0;
                m_cout[k] <= 1'b0;
                m_err[k]  <= 1'b0;
            end else if (m_left[k] > 0) begin
                m_left[k] <= m_left[k] - 1;
                if (m_left[k] == 1) begin
                    m_done[k] <= 1'b1;
                    m_sum[k]  <= m_pend[k][31:0];
                    m_cout[k] <= m_pend[k][32];
                end
            end else begin
                m_done[k] <= 1'b0;
                if (start) begin
                    m_left[k] <= nd_of(k);
                    m_sum[k]  <= '0;
                    m_cout[k] <= 1'b0;
                    m_err[k]  <= ref_err(a_in, b_in, nd_of(k));
                    m_pend[k] <= ref_add(a_in, b_in, cin, nd_of(k));
                end
            end
        end
    end

    // Compare every build against the model on each falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            check($sformatf("busy[%0d]", k), 33'(busy_v[k]), 33'(m_left[k] != 0));
            check($sformatf("done[%0d]", k), 33'(done_v[k]), 33'(m_done[k]));
            check($sformatf("err[%0d]", k),  33'(err_v[k]),  33'(m_err[k]));
            if (m_left[k] == 0) begin
                check($sformatf("sum[%0d]", k),  33'(sum_v[k]),  33'(m_sum[k]));
                check($sformatf("cout[%0d]", k), 33'(cout_v[k]), 33'(m_cout[k]));
            end
        end
    end

    // ---------------- directed helpers (4-digit build) ----------------
    task automatic wait_done(output int cyc, output int nbusy);
        cyc   = 1;
        nbusy = int'(busy_v[0]);
        while (!done_v[0] && cyc < 30) begin
            @(negedge clk);
            cyc++;
            nbusy += int'(busy_v[0]);
        end
    endtask

    task automatic run_op(input string nm, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic [15:0] es, input logic ec,
                          input logic ee);
        int cyc, nbusy;
        @(negedge clk);
        a_in  = {16'h0, av};
        b_in  = {16'h0, bv};
        cin   = ci;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, nbusy);
        check({nm, "_latency"}, 33'(cyc), 33'd5);
        check({nm, "_busy_cycles"}, 33'(nbusy), 33'd4);
        check({nm, "_sum"}, 33'(sum4), 33'(es));
        check({nm, "_cout"}, 33'(cout_v[0]), 33'(ec));
        check({nm, "_err"}, 33'(err_v[0]), 33'(ee));
    endtask

    function automatic logic [31:0] rand_bcd();
        logic [31:0] v;
        for (int i = 0; i < 8; i++)
            v[i*4 +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                                       : 4'($urandom_range(0, 9));
        return v;
    endfunction

    initial begin
        int cyc, nbusy, ndone, cnt;

        // Literal anchors for the reference model itself.
        check("model_0123_0456", ref_add(32'h0123, 32'h0456, 1'b0, 4), {1'b0, 32'h0579});
        check("model_9999_0001", ref_add(32'h9999, 32'h0001, 1'b0, 4), {1'b1, 32'h0000});
        check("model_000A_0005", ref_add(32'h000A, 32'h0005, 1'b0, 4), {1'b0, 32'h0015});
        check("model_err_000A",  33'(ref_err(32'h000A, 32'h0005, 4)), 33'd1);
        check("model_8dig",      ref_add(32'h99999999, 32'h0, 1'b1, 8), {1'b1, 32'h0});

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy", 33'(busy_v[0]), 33'd0);
        check("rst_done", 33'(done_v[0]), 33'd0);
        check("rst_sum",  33'(sum4), 33'd0);
        check("rst_cout", 33'(cout_v[0]), 33'd0);
        check("rst_err",  33'(err_v[0]), 33'd0);
        rst_n = 1'b1;

        // Directed operations.
        run_op("basic",   16'h0123, 16'h0456, 1'b0, 16'h0579, 1'b0, 1'b0);
        run_op("wrap",    16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("cin_rip", 16'h0999, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0);
        run_op("invalid", 16'h000A, 16'h0005, 1'b0, 16'h0015, 1'b0, 1'b1);

        // Start during RUN is ignored; start during DONE is accepted.
        @(negedge clk);
        a_in = 32'h1234; b_in = 32'h4321; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a_in = 32'h9999; b_in = 32'h9999; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        cnt   = 0;
        while (!done_v[0] && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
        check("ignored_start_sum", 33'(sum4), 33'h5555);
        check("ignored_start_cout", 33'(cout_v[0]), 33'd0);
        ndone += int'(done_v[0]);
        a_in = 32'h0250; b_in = 32'h0750; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, nbusy);
        ndone += int'(done_v[0]);
        check("b2b_latency", 33'(cyc), 33'd5);
        check("b2b_done_pulses", 33'(ndone), 33'd2);
        check("b2b_sum", 33'(sum4), 33'h1001);
        check("b2b_cout", 33'(cout_v[0]), 33'd0);

        // Asynchronous reset while processing digit 2.
        @(negedge clk);
        a_in = 32'h1111; b_in = 32'h2222; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 33'(busy_v[0]), 33'd0);
        check("async_rst_done", 33'(done_v[0]), 33'd0);
        check("async_rst_sum",  33'(sum4), 33'd0);
        check("async_rst_cout", 33'(cout_v[0]), 33'd0);
        check("async_rst_err",  33'(err_v[0]), 33'd0);
        repeat (3) begin
            @(negedge clk);
            check("no_done_after_rst", 33'(done_v[0]), 33'd0);
        end
        rst_n = 1'b1;
        run_op("post_rst", 16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Randomized operations; start sometimes held over several cycles.
        for (int n = 0; n < 150; n++) begin
            cnt = 0;
            while ((m_left[0] != 0 || m_left[1] != 0 || m_left[2] != 0) && cnt < 40) begin
                @(negedge clk);
                cnt++;
            end
            if (cnt >= 40) check("idle_wait_timeout", 33'(cnt), 33'd0);
            a_in  = rand_bcd();
            b_in  = rand_bcd();
            cin   = 1'($urandom_range(0, 1));
            start = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            start = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
